// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-port RAM access sequencer with MAR/MBR and read-latency wait
module mem_access_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr_in,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  output logic        ram_ena,
  output logic        ram_wea
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  // Last value of the wait counter; the capture happens on that edge.
  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  mar_q, mar_d;
  logic [15:0] mbr_q, mbr_d;
  logic        we_q, we_d;
  logic [1:0]  cnt_q, cnt_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mar_q   <= 8'h00;
      mbr_q   <= 16'h0000;
      we_q    <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; request inputs are only looked at in IDLE so they cannot disturb an access.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          mar_d   = addr_in;
          we_d    = we;
          if (we) begin
            mbr_d = wdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = 2'd0;
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          mbr_d   = ram_dout;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM strobes are masked by rst so a reset landing in ACCESS never issues a write.
  assign busy     = (state_q == ACCESS) || (state_q == WAIT);
  assign done     = (state_q == DONE);
  assign ram_ena  = busy && !rst;
  assign ram_wea  = (state_q == ACCESS) && we_q && !rst;
  assign ram_addr = mar_q;
  assign ram_din  = mbr_q;
  assign rdata    = mbr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl at RD_LAT 1 and 2
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr_in = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic        mem_init = 1'b1;

  logic        busy1, done1, ram_ena1, ram_wea1;
  logic [15:0] rdata1, ram_din1, ram_dout1;
  logic [7:0]  ram_addr1;
  logic        busy2, done2, ram_ena2, ram_wea2;
  logic [15:0] rdata2, ram_din2, ram_dout2;
  logic [7:0]  ram_addr2;

  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];
  logic [15:0] pipe2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr_in(addr_in), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .ram_addr(ram_addr1), .ram_din(ram_din1),
    .ram_dout(ram_dout1), .ram_ena(ram_ena1), .ram_wea(ram_wea1)
  );

  mem_access_ctrl #(.RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr_in(addr_in), .wdata(wdata),
    .busy(busy2), .done(done2), .rdata(rdata2), .ram_addr(ram_addr2), .ram_din(ram_din2),
    .ram_dout(ram_dout2), .ram_ena(ram_ena2), .ram_wea(ram_wea2)
  );

  // RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 16'h0000;
      mem1[8'hFF] <= 16'h1234;
    end else if (ram_ena1 && ram_wea1) begin
      mem1[ram_addr1] <= ram_din1;
    end
    ram_dout1 <= mem1[ram_addr1];
  end

  // RAM model with two-cycle read latency
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem2[i] <= 16'h0000;
      mem2[8'hFF] <= 16'h1234;
    end else if (ram_ena2 && ram_wea2) begin
      mem2[ram_addr2] <= ram_din2;
    end
    pipe2     <= mem2[ram_addr2];
    ram_dout2 <= pipe2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_init = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mem_init = 1'b0;
    tick();
    n_checks++;
    if ({busy1, done1, ram_ena1, ram_wea1, rdata1, ram_addr1, ram_din1} !== {4'b0000, 16'h0, 8'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_dut1: busy/done/ena/wea/rdata/addr/din got %b%b%b%b %h %h %h, want 0000 0000 00 0000",
               busy1, done1, ram_ena1, ram_wea1, rdata1, ram_addr1, ram_din1);
    end
    n_checks++;
    if ({busy2, done2, ram_ena2, ram_wea2, rdata2, ram_addr2, ram_din2} !== {4'b0000, 16'h0, 8'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_dut2: busy/done/ena/wea/rdata/addr/din got %b%b%b%b %h %h %h, want 0000 0000 00 0000",
               busy2, done2, ram_ena2, ram_wea2, rdata2, ram_addr2, ram_din2);
    end
  endtask

  task automatic test_write();
    req = 1'b1; we = 1'b1; addr_in = 8'h3C; wdata = 16'hA5F0;
    tick();
    req = 1'b0; we = 1'b0; addr_in = 8'h00; wdata = 16'h0000;
    n_checks++;
    if ({ram_ena1, ram_wea1, ram_addr1, ram_din1, busy1, done1} !== {2'b11, 8'h3C, 16'hA5F0, 2'b10}) begin
      n_fail++;
      $display("FAIL write_access_dut1: ena/wea/addr/din/busy/done got %b%b %h %h %b%b, want 11 3c a5f0 10",
               ram_ena1, ram_wea1, ram_addr1, ram_din1, busy1, done1);
    end
    n_checks++;
    if ({ram_ena2, ram_wea2, ram_addr2, ram_din2, busy2, done2} !== {2'b11, 8'h3C, 16'hA5F0, 2'b10}) begin
      n_fail++;
      $display("FAIL write_access_dut2: ena/wea/addr/din/busy/done got %b%b %h %h %b%b, want 11 3c a5f0 10",
               ram_ena2, ram_wea2, ram_addr2, ram_din2, busy2, done2);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_checks++;
      if ({done1, done2, busy1, busy2, ram_ena1, ram_ena2} !== {(c == 2), (c == 2), 4'b0000}) begin
        n_fail++;
        $display("FAIL write_done_c%0d: done1/done2/busy1/busy2/ena1/ena2 got %b%b%b%b%b%b, want %b%b0000",
                 c, done1, done2, busy1, busy2, ram_ena1, ram_ena2, (c == 2), (c == 2));
      end
    end
    n_checks++;
    if ({rdata1, rdata2} !== {16'hA5F0, 16'hA5F0}) begin
      n_fail++;
      $display("FAIL write_mbr: rdata1 %h rdata2 %h, want a5f0 a5f0", rdata1, rdata2);
    end
  endtask

  task automatic test_read(input logic [7:0] a, input logic [15:0] prev, input logic [15:0] exp);
    req = 1'b1; we = 1'b0; addr_in = a; wdata = 16'hDEAD;
    tick();
    req = 1'b0; wdata = 16'h0000;
    for (int c = 1; c <= 6; c++) begin
      n_checks++;
      if ({ram_wea1, ram_wea2, done1, done2, busy1, busy2} !==
          {2'b00, (c == 3), (c == 4), (c <= 2), (c <= 3)}) begin
        n_fail++;
        $display("FAIL read_%h_c%0d: wea1/wea2/done1/done2/busy1/busy2 got %b%b%b%b%b%b, want 00%b%b%b%b",
                 a, c, ram_wea1, ram_wea2, done1, done2, busy1, busy2, (c == 3), (c == 4), (c <= 2), (c <= 3));
      end
      if (c == 1) begin
        n_checks++;
        if ({rdata1, rdata2, ram_addr1, ram_addr2} !== {prev, prev, a, a}) begin
          n_fail++;
          $display("FAIL read_%h_hold: rdata1 %h rdata2 %h addr1 %h addr2 %h, want %h %h %h %h",
                   a, rdata1, rdata2, ram_addr1, ram_addr2, prev, prev, a, a);
        end
      end
      if (c == 3 || c == 6) begin
        n_checks++;
        if (rdata1 !== exp) begin
          n_fail++;
          $display("FAIL read_%h_rdata1_c%0d: got %h, want %h", a, c, rdata1, exp);
        end
      end
      if (c == 4 || c == 6) begin
        n_checks++;
        if (rdata2 !== exp) begin
          n_fail++;
          $display("FAIL read_%h_rdata2_c%0d: got %h, want %h", a, c, rdata2, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_busy_inputs();
    int nd1 = 0;
    int nd2 = 0;
    req = 1'b1; we = 1'b0; addr_in = 8'h3C;
    tick();
    req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      n_checks++;
      if ({ram_addr1, ram_addr2, ram_wea1, ram_wea2} !== {8'h3C, 8'h3C, 2'b00}) begin
        n_fail++;
        $display("FAIL busy_inputs_c%0d: addr1 %h addr2 %h wea %b%b, want 3c 3c 00",
                 c, ram_addr1, ram_addr2, ram_wea1, ram_wea2);
      end
      nd1 += int'(done1);
      nd2 += int'(done2);
      if (c == 2) begin
        req = 1'b1; we = 1'b1; addr_in = 8'h00; wdata = 16'hFFFF;
      end else if (c == 3) begin
        req = 1'b0; we = 1'b0; addr_in = 8'h00; wdata = 16'h0000;
      end
      tick();
    end
    n_checks++;
    if (nd1 != 1 || nd2 != 1) begin
      n_fail++;
      $display("FAIL busy_inputs_done_count: dut1 %0d dut2 %0d, want 1 1", nd1, nd2);
    end
    n_checks++;
    if ({rdata1, rdata2, mem1[0], mem2[0]} !== {16'hA5F0, 16'hA5F0, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL busy_inputs_data: rdata1 %h rdata2 %h mem1[0] %h mem2[0] %h, want a5f0 a5f0 0000 0000",
               rdata1, rdata2, mem1[0], mem2[0]);
    end
  endtask

  task automatic test_reset_mid();
    req = 1'b1; we = 1'b1; addr_in = 8'h55; wdata = 16'h7777;
    tick();
    req = 1'b0; we = 1'b0; addr_in = 8'h00; wdata = 16'h0000;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ram_ena1, ram_wea1, ram_ena2, ram_wea2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_strobes: ena1/wea1/ena2/wea2 got %b%b%b%b, want 0000",
               ram_ena1, ram_wea1, ram_ena2, ram_wea2);
    end
    tick();
    rst = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      n_checks++;
      if ({busy1, done1, busy2, done2, rdata1, rdata2, ram_addr1} !== {4'b0000, 16'h0, 16'h0, 8'h0}) begin
        n_fail++;
        $display("FAIL reset_mid_c%0d: busy/done %b%b%b%b rdata1 %h rdata2 %h addr1 %h, want 0000 0000 0000 00",
                 c, busy1, done1, busy2, done2, rdata1, rdata2, ram_addr1);
      end
      tick();
    end
    n_checks++;
    if ({mem1[8'h55], mem2[8'h55]} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_no_write: mem1 %h mem2 %h, want 0000 0000", mem1[8'h55], mem2[8'h55]);
    end
  endtask

  task automatic test_reset_wait();
    req = 1'b1; we = 1'b0; addr_in = 8'hFF;
    tick();
    req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({rdata2, done2, busy2} !== {16'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_wait_c4: rdata2 %h done2 %b busy2 %b, want 0000 0 0", rdata2, done2, busy2);
    end
    tick();
    n_checks++;
    if ({rdata2, done2} !== {16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_wait_c5: rdata2 %h done2 %b, want 0000 0", rdata2, done2);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:1] eb1 = 10'b0000110011;
    logic [10:1] ed1 = 10'b0001000100;
    logic [10:1] eb2 = 10'b0011100111;
    logic [10:1] ed2 = 10'b0100001000;
    int nd1 = 0;
    int nd2 = 0;
    req = 1'b1; we = 1'b0; addr_in = 8'h3C;
    tick();
    for (int c = 1; c <= 10; c++) begin
      n_checks++;
      if ({busy1, done1, ram_ena1, busy2, done2, ram_ena2} !==
          {eb1[c], ed1[c], eb1[c], eb2[c], ed2[c], eb2[c]}) begin
        n_fail++;
        $display("FAIL b2b_c%0d: busy1/done1/ena1/busy2/done2/ena2 got %b%b%b%b%b%b, want %b%b%b%b%b%b",
                 c, busy1, done1, ram_ena1, busy2, done2, ram_ena2,
                 eb1[c], ed1[c], eb1[c], eb2[c], ed2[c], eb2[c]);
      end
      nd1 += int'(done1);
      nd2 += int'(done2);
      if (c == 6) req = 1'b0;
      tick();
    end
    n_checks++;
    if (nd1 != 2 || nd2 != 2 || rdata1 !== 16'hA5F0 || rdata2 !== 16'hA5F0) begin
      n_fail++;
      $display("FAIL b2b_summary: done pulses %0d %0d rdata %h %h, want 2 2 a5f0 a5f0", nd1, nd2, rdata1, rdata2);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(8'h3C, 16'hA5F0, 16'hA5F0);
    test_read(8'hFF, 16'hA5F0, 16'h1234);
    test_busy_inputs();
    test_reset_mid();
    test_reset_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
